totient_seq_display: RTL
========================

# totient_seq_display

Parametrised Euler-totient sequencer with a multiplexed multi-digit 7-segment output. The block steps n through 1..N_MAX in either direction and computes phi(n) at run time with an iterative gcd engine, so it needs no ROM. It converts each result to BCD and drives a time-multiplexed common-segment display. It is the front-end display source for the design-problem board.

## Interface
- N_MAX, 99: highest n in the sequence; requires N_MAX < 10**DIGITS.
- W, 7: width of n/phi datapath; must satisfy 2**W > N_MAX.
- DIGITS, 2: number of displayed decimal digits of phi.
- REFRESH_DIV, 1000: clk_0 cycles each digit stays selected.

- clk_0  in  1  single clock; all state updates on rising edge.
- R  in  1  reset, asynchronous, active-low.
- step  in  1  single-advance request; sampled in IDLE only.
- run  in  1  auto-advance; while high, every IDLE cycle is an advance request.
- dir  in  1  0 = n increments, 1 = n decrements; sampled when the advance is accepted.
- n_cur  out  W  current n.
- phi  out  W  phi(n_cur); meaningful when valid=1.
- valid  out  1  phi and display digits correspond to n_cur.
- busy  out  1  computation in progress.
- A, B, C, D, E, F, G  out  1 each  segments of selected digit, active-high (1 = lit).
- dig_sel  out  DIGITS  one-hot digit enable; bit 0 = least significant digit.

## Operation
- Reset values:
  - n_cur=1, phi=0, valid=0, busy=1, FSM=SCAN, k=1, cnt=0.
  - Display BCD regs all 0, so {A..G}=1111110 (digit 0).
  - dig_sel=…0001, refresh counter=0.
- FSM states: IDLE, SCAN, GCD, CONV, DONE.
- IDLE:
  - busy=0, valid=1.
  - An advance request is step|run; step and run together give one advance.
  - On a request, update n_cur:
    - dir=0: n+1, wrapping N_MAX→1.
    - dir=1: n−1, wrapping 1→N_MAX.
  - Also on a request: k=1, cnt=0, valid=0, busy=1, next state SCAN.
  - Otherwise stay in IDLE.
- SCAN: load a=k, b=n_cur; go to GCD.
- GCD: one subtractive step per cycle.
  - a>b: a−=b.
  - b>a: b−=a.
  - a==b:
    - If a==1, cnt+1.
    - If k==n_cur, go to CONV; else k+1 and go to SCAN.
- CONV: double-dabble cnt into DIGITS BCD nibbles, one shift per cycle, exactly W cycles; then go to DONE.
- DONE: latch phi=cnt and the BCD result into the display regs; set valid=1, busy=0; go to IDLE.
- The display regs hold the previous result for the whole computation, so there is no flicker or partial value.
- Requests made while busy are ignored, not queued. step is level-sampled, so the driver must supply one-cycle pulses.
- Display path:
  - The refresh counter counts 0..REFRESH_DIV−1; at terminal count dig_sel rotates left, wrapping MSD→LSD.
  - Segments show the nibble for the selected digit: decimal 0–9 patterns, 0 = 1111110, 1 = 0110000, etc.
  - Leading-zero blanking: any zero digit above the highest non-zero digit drives 0000000. Digit 0 is never blanked.
- A reset asserted mid-operation aborts immediately and returns all state to the reset values; n restarts at 1.

## Timing
- After reset release, the first edge enters the n=1 computation. valid rises after edge W+3: SCAN, GCD, W×CONV, DONE. With W=7 that is 10 edges.
- Per-n latency from the accepting edge = 1 + Σ_{k=1..n}(2 + s_k) + W + 1 cycles, where s_k is the subtraction count for gcd(k,n).
- valid falls on the accepting edge and rises with the DONE edge.
- n_cur changes on the accepting edge.
- Display update latency after DONE is 0 cycles for the segment lines (combinational from the regs and dig_sel).
- dig_sel period = DIGITS×REFRESH_DIV cycles; it is unaffected by FSM activity.

## Structure
- totient_pkg holds:
  - the state enum;
  - the 10 segment constants plus SEG_BLANK;
  - a clog2-based width helper;
  - the N_MAX/DIGITS legality check function.
- One sub-module, totient_seg_mux, contains the refresh counter, dig_sel rotation, blanking and decoder. Its inputs are the BCD vector, clk_0 and R. The FSM/gcd/double-dabble logic stays in the top.

## Test plan
- Reset release, idle inputs → valid=1 after 10 edges; n_cur=1, phi=1; dig_sel=01 shows 0110000; digit 1 blanked (0000000).
- Eleven step pulses, dir=0 → n_cur=12, phi=4; digit 0 = 0110011, digit 1 blank.
- One step with dir=1 from n=1 → n_cur=99, phi=60; digit 1 = 1011111, digit 0 = 1111110.
- run=1 for a full sweep → phi matches the software model for n=1..99; after 99 comes n=1. step pulses while busy do not change n_cur.
- n=97 → phi=96, with digits 9 (1111011) and 6 (1011111) alternating every REFRESH_DIV cycles.
- R pulsed low during GCD at n=50 → all outputs return to their reset values asynchronously; the sequence restarts with n=1, phi=1.

Source files
------------

// File: rtl/totient_pkg.sv
// Shared types, segment patterns and parameter helpers for the totient sequencer.
package totient_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_GCD,
        ST_CONV,
        ST_DONE
    } state_t;

    // Segment patterns ordered {A,B,C,D,E,F,G}, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    // N_MAX must fit in DIGITS decimal digits and in a W-bit datapath
    function automatic bit params_legal(input int unsigned n_max,
                                        input int unsigned digits,
                                        input int unsigned w);
        longint unsigned lim;
        lim = 64'd1;
        for (int unsigned i = 0; i < digits; i++) lim = lim * 64'd10;
        return (n_max >= 32'd1) && (64'(n_max) < lim) && (w < 32'd32) &&
               ((64'd1 << w) > 64'(n_max));
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/totient_seq_display_if.sv
// Control, result and display bundle of the totient sequencer.
interface totient_seq_display_if #(
    parameter int unsigned W      = 7,
    parameter int unsigned DIGITS = 2
);
    logic              step;
    logic              run;
    logic              dir;
    logic [W-1:0]      n_cur;
    logic [W-1:0]      phi;
    logic              valid;
    logic              busy;
    logic              A, B, C, D, E, F, G;
    logic [DIGITS-1:0] dig_sel;

    modport master (
        output step, run, dir,
        input  n_cur, phi, valid, busy, A, B, C, D, E, F, G, dig_sel
    );

    modport slave (
        input  step, run, dir,
        output n_cur, phi, valid, busy, A, B, C, D, E, F, G, dig_sel
    );
endinterface

// File: rtl/totient_seg_mux.sv
// Time-multiplexed 7-segment driver: refresh counter, one-hot digit rotation,
// leading-zero blanking and BCD decode.
module totient_seg_mux
    import totient_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                  clk_0,
    input  logic                  R,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [6:0]            seg_c
);

    localparam int unsigned REF_W = width_for(REFRESH_DIV);

    logic [REF_W-1:0] ref_cnt;
    logic             keep;

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            ref_cnt <= '0;
            dig_sel <= DIGITS'(1);
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            dig_sel <= (dig_sel << 1) | (dig_sel >> (DIGITS - 1));
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Walk from the MSD down; a digit lights once any digit at or above it is non-zero
    always_comb begin
        seg_c = SEG_BLANK;
        keep  = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            keep = keep | (bcd[4*i +: 4] != 4'd0) | (i == 0);
            if (dig_sel[i]) seg_c = keep ? seg_of(bcd[4*i +: 4]) : SEG_BLANK;
        end
    end

endmodule

// File: rtl/totient_seq_display.sv
// Euler-totient sequencer: steps n over 1..N_MAX, computes phi(n) with a
// subtractive gcd loop plus double-dabble, and drives a multiplexed display.
module totient_seq_display
    import totient_pkg::*;
#(
    parameter int unsigned N_MAX       = 99,
    parameter int unsigned W           = 7,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                 clk_0,
    input  logic                 R,
    totient_seq_display_if.slave bus
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CONV_W = width_for(W);

    if (!params_legal(N_MAX, DIGITS, W)) begin : g_bad_params
        $error("totient_seq_display: N_MAX does not fit DIGITS or W");
    end

    state_t              state;
    logic [W-1:0]        k, cnt, a, b, sh_bin;
    logic [W-1:0]        n_adv, cnt_nxt;
    logic [BCD_W-1:0]    sh_bcd, bcd_adj, disp_bcd;
    logic [CONV_W-1:0]   conv_cnt;
    logic                req;
    logic [6:0]          seg_c;

    assign req     = bus.step | bus.run;
    assign cnt_nxt = cnt + W'(a == W'(1));

    // Next n with wrap at both ends of 1..N_MAX
    always_comb begin
        n_adv = bus.n_cur;
        if (bus.dir) n_adv = (bus.n_cur == W'(1))     ? W'(N_MAX) : bus.n_cur - W'(1);
        else         n_adv = (bus.n_cur == W'(N_MAX)) ? W'(1)     : bus.n_cur + W'(1);
    end

    // Double-dabble add-3 correction ahead of each shift
    always_comb begin
        bcd_adj = sh_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            state     <= ST_SCAN;
            bus.n_cur <= W'(1);
            bus.phi   <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b1;
            k         <= W'(1);
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            sh_bin    <= '0;
            sh_bcd    <= '0;
            disp_bcd  <= '0;
            conv_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        bus.n_cur <= n_adv;
                        k         <= W'(1);
                        cnt       <= '0;
                        bus.valid <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    a     <= k;
                    b     <= bus.n_cur;
                    state <= ST_GCD;
                end
                ST_GCD: begin
                    if (a > b) begin
                        a <= a - b;
                    end else if (b > a) begin
                        b <= b - a;
                    end else begin
                        cnt <= cnt_nxt;
                        if (k == bus.n_cur) begin
                            sh_bin   <= cnt_nxt;
                            sh_bcd   <= '0;
                            conv_cnt <= '0;
                            state    <= ST_CONV;
                        end else begin
                            k     <= k + W'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_CONV: begin
                    sh_bcd   <= BCD_W'({bcd_adj, sh_bin[W-1]});
                    sh_bin   <= sh_bin << 1;
                    conv_cnt <= conv_cnt + CONV_W'(1);
                    if (conv_cnt == CONV_W'(W - 1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    bus.phi   <= cnt;
                    disp_bcd  <= sh_bcd;
                    bus.valid <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    totient_seg_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_seg_mux (
        .clk_0   (clk_0),
        .R       (R),
        .bcd     (disp_bcd),
        .dig_sel (bus.dig_sel),
        .seg_c   (seg_c)
    );

    assign {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = seg_c;

endmodule
